// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// FSM encoding and the default operand width.
package serial_adder_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder used for each serial step.
// Purely combinational; state lives in serial_adder.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ c;
  assign cout = (x & y) | (c & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             cy;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] res_sh;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .c   (cy),
    .s   (fa_s),
    .cout(fa_c)
  );

  // Partial result keeps only the bits gathered so far; the
  // last step's bit completes it into the full sum.
  assign res_sh = {fa_s, res};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      cy    <= 1'b0;
      res   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            cy    <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          cy   <= fa_c;
          res  <= res_sh[WIDTH-1:1];
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= res_sh;
            cout  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // cy is the carry into the MSB at this step
            ovf   <= cy ^ fa_c;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8).
// Checks ovf too when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           k;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;

  logic [W-1:0] prev_s;
  logic         prev_co;
  bit           have_prev = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("sum", 32'(sum), 32'(e.s));
        check("cout", 32'(cout), 32'(e.co));
        check("latency", 32'(edge_cnt), 32'(e.k + W));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ov));
`endif
      end
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input bit mess);
    exp_t e;
    int   t;
    int   n_busy;
    bit   seen;
    @(negedge clk);
    a = x;
    b = y;
    cin = ci;
    start = 1'b1;
    t = int'(x) + int'(y) + int'(ci);
    e.s = t[W-1:0];
    e.co = t[W];
    e.ov = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
    e.k = edge_cnt + 1;
    q.push_back(e);
    n_busy = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) n_busy++;
      if (have_prev && i == 3) begin
        check("hold_sum_in_shift", 32'(sum), 32'(prev_s));
        check("hold_cout_in_shift", 32'(cout), 32'(prev_co));
      end
      start = mess ? 1'($urandom) : 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
    end
    start = 1'b0;
    check("done_timeout", 32'(seen), 32'd1);
    check("busy_cycles", 32'(n_busy), 32'(W));
    check("busy_at_done", 32'(busy), 32'd0);
    prev_s = e.s;
    prev_co = e.co;
    have_prev = 1;
  endtask

  task automatic idle_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      check("hold_sum_idle", 32'(sum), 32'(prev_s));
      check("hold_cout_idle", 32'(cout), 32'(prev_co));
      check("done_idle", 32'(done), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    a = '1;
    b = '1;
    cin = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    start = 1'b0;
    rst_n = 1'b1;
    prev_s = '0;
    prev_co = 1'b0;
    have_prev = 1;
    idle_hold(2);

    run_op(8'h00, 8'h00, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'hA5, 8'h5A, 1'b1, 0);
    idle_hold(4);
    run_op(8'h7F, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'h80, 1'b0, 0);
    run_op(8'h10, 8'h20, 1'b0, 1);

    // Abort: reset lands on the 4th SHIFT edge.
    @(negedge clk);
    a = 8'h55;
    b = 8'h66;
    cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    prev_s = '0;
    prev_co = 1'b0;
    idle_hold(12);
    run_op(8'h03, 8'h04, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom),
             bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_hold(2);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous active-low reset (one clock, reset synchronous and active-low).
REQ-004 SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: operand A, captured on an accepted start.
REQ-006 SHALL have port b, input, WIDTH bits: operand B, captured on an accepted start.
REQ-007 SHALL have port cin, input, 1 bit: carry-in, captured on an accepted start.
REQ-008 SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 SHALL have port sum, output, WIDTH bits: registered result, A+B+cin mod 2^WIDTH.
REQ-011 SHALL have port cout, output, 1 bit: registered carry-out of the full WIDTH-bit addition.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE, all registered.
REQ-013 SHALL take transition IDLE->SHIFT on the edge where start=1 and capture a, b and cin into shift registers and the carry flop at that edge.
REQ-014 SHALL, in SHIFT, add on each edge the LSBs of the A/B shift registers plus the carry flop through one full adder, shift the sum bit into the MSB of the result register, update the carry flop and shift A/B right by one.
REQ-015 SHALL count bits with a counter of width clog2(WIDTH+1), take transition SHIFT->DONE on the edge that processes bit WIDTH-1, and update sum and cout at that same edge.
REQ-016 SHALL hold done=1 for exactly one cycle in DONE and take transition DONE->IDLE unconditionally.
REQ-017 SHALL have a latency of exactly WIDTH edges: if start is accepted at edge k, done is high in the cycle following edge k+WIDTH.
REQ-018 SHALL ignore start while in SHIFT or DONE, with no queuing; a fresh start is needed in IDLE.
REQ-019 SHALL hold sum and cout stable from DONE until the end of the next accepted operation.
REQ-020 SHALL NOT let changes on a, b or cin after capture affect the operation in progress.
REQ-021 SHALL give all outputs glitch-free registered values, with no combinational path from inputs to outputs.

Reset
REQ-022 SHALL, when rst_n=0 at a rising edge, force the state to IDLE and set busy=0, done=0, sum=0, cout=0, the counter to 0 and the carry flop to 0.
REQ-023 SHALL abort an operation in progress when reset is asserted mid-SHIFT, with no done pulse and the result cleared to 0.
REQ-024 SHALL give start priority below reset: start=1 together with rst_n=0 is not accepted.

Configuration
REQ-025 SHALL, with macro SERIAL_ADDER_OVF_EN defined, add output port ovf, 1 bit: signed overflow, equal to the carry into the MSB XOR the carry out, registered with sum, reset to 0 and held like sum.
REQ-026 SHALL, without SERIAL_ADDER_OVF_EN, have no ovf port or logic, with all other behaviour identical.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant in shared package serial_adder_pkg.
REQ-028 SHALL instantiate exactly one combinational sub-module full_adder (x, y, c -> s, cout) for the per-bit add; the serial_adder module owns all sequential logic.

Verification
REQ-029 SHALL verify, with WIDTH=8: a=0x00, b=0x00, cin=0 -> done 8 edges after start, sum=0x00, cout=0.
REQ-030 SHALL verify: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; busy high for exactly 8 cycles.
REQ-031 SHALL verify: a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; sum and cout held after done until the next start.
REQ-032 SHALL verify, with SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; and a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-033 SHALL verify: start with a=0x10, b=0x20, re-pulse start with different operands during SHIFT -> the second start is ignored and the result is 0x30.
REQ-034 SHALL verify: rst_n=0 at the 4th SHIFT edge -> state IDLE, no done pulse, sum=0, cout=0; a subsequent start of 0x03+0x04 gives 0x07.
